// File: rtl/ecg_pool_pkg.sv
// Shared defaults and helpers for the max-pool window packer.
package ecg_pool_pkg;

  localparam int POOL_DATA_W = 10;
  localparam int POOL_WIN    = 7;
  localparam int POOL_STRIDE = 7;
  localparam int POOL_WIN_W  = POOL_WIN * POOL_DATA_W;

  // Most negative sample: padding with it leaves a downstream max unchanged.
  localparam logic [POOL_DATA_W-1:0] PAD_VAL = {1'b1, {(POOL_DATA_W-1){1'b0}}};

  typedef logic signed [POOL_DATA_W-1:0] pool_sample_t;

  function automatic int fill_w(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/pool_shift_window.sv
// Sample shift register for the window packer: holds the WIN-1 most recent samples
// and presents the WIN-deep window they form with the incoming sample.
module pool_shift_window
  import ecg_pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int WIN    = POOL_WIN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  output logic [WIN*DATA_W-1:0]    win_data
);

  localparam int HOLD_W = (WIN - 1) * DATA_W;

  logic [HOLD_W-1:0] held_q;
  logic [HOLD_W-1:0] held_d;

  // Oldest sample sits in the top slot, the incoming sample in the bottom slot.
  assign win_data = {held_q, din};

  always_comb begin
    held_d = held_q;
    if (shift_en) begin
      held_d = win_data[HOLD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/pool_window_packer.sv
// Sliding-window packer feeding the max-pool compare stage.
// Define POOL_PAD_PARTIAL_EN to emit frame-end partial windows padded with PAD; otherwise they are dropped.
module pool_window_packer
  import ecg_pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int WIN    = POOL_WIN,
  parameter int STRIDE = POOL_STRIDE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIN*DATA_W-1:0]    out_data,
  output logic                     out_last
);

  localparam int                WIN_W     = WIN * DATA_W;
  localparam int                FILL_W    = fill_w(WIN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);
  localparam logic [FILL_W-1:0] FILL_KEEP = FILL_W'(WIN - STRIDE);

  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              out_valid_q, out_valid_d;
  logic [WIN_W-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [WIN_W-1:0]  win_data;
  logic              accept;
  logic              win_done;

`ifdef POOL_PAD_PARTIAL_EN
  localparam logic [DATA_W-1:0] PAD = {1'b1, {(DATA_W-1){1'b0}}};

  // Move the n newest samples up to the oldest slots and pad the rest.
  function automatic logic [WIN_W-1:0] pad_window(input logic [WIN_W-1:0] w,
                                                  input logic [FILL_W-1:0] n);
    logic [WIN_W-1:0] r;
    int               gap;
    gap = WIN - int'(n);
    r   = w << (gap * DATA_W);
    for (int s = 0; s < WIN; s++) begin
      if (s < gap) begin
        r[s*DATA_W +: DATA_W] = PAD;
      end
    end
    return r;
  endfunction
`endif

  // A single output register still streams at full rate: a transfer frees it in the same cycle.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign fill_inc  = fill_q + FILL_W'(1);
  assign win_done  = accept && (fill_inc == FILL_FULL);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  pool_shift_window #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (in_data),
    .win_data (win_data)
  );

  always_comb begin
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      fill_d = fill_inc;
      if (win_done) begin
        out_valid_d = 1'b1;
        out_data_d  = win_data;
        out_last_d  = in_last;
        fill_d      = in_last ? '0 : FILL_KEEP;
      end else if (in_last) begin
        fill_d = '0;
`ifdef POOL_PAD_PARTIAL_EN
        out_valid_d = 1'b1;
        out_data_d  = pad_window(win_data, fill_inc);
        out_last_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_pool_window_packer.sv
// Directed, table-driven bench for pool_window_packer (STRIDE=7 and STRIDE=2 instances).
module tb_pool_window_packer;

  localparam int DW = 10;
  localparam int WN = 7;
  localparam int WW = DW * WN;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic signed [DW-1:0] a_in_data;
  logic [WW-1:0]        a_out_data;
  logic                 b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic signed [DW-1:0] b_in_data;
  logic [WW-1:0]        b_out_data;

  pool_window_packer #(.DATA_W(DW), .WIN(WN), .STRIDE(7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
  );

  pool_window_packer #(.DATA_W(DW), .WIN(WN), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  // u selects the instance (0: STRIDE=7, 1: STRIDE=2); eir is in_ready before the edge,
  // ev/ed/el the outputs after it (ed/el checked only when ev is set).
  typedef struct {
    bit            u;
    bit            v;
    logic [DW-1:0] d;
    bit            l;
    bit            rdy;
    bit            eir;
    bit            ev;
    logic [WW-1:0] ed;
    bit            el;
  } row_t;

  row_t rows[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [WW-1:0] pk(input int a, input int b, input int c, input int d,
                                       input int e, input int f, input int g);
    return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f), 10'(g)};
  endfunction

  function automatic logic [WW-1:0] seq(input int base);
    return pk(base, base + 1, base + 2, base + 3, base + 4, base + 5, base + 6);
  endfunction

  task automatic add(input bit u, input bit v, input int d, input bit l, input bit rdy,
                     input bit eir, input bit ev, input logic [WW-1:0] ed, input bit el);
    row_t r;
    r.u = u; r.v = v; r.d = 10'(d); r.l = l; r.rdy = rdy;
    r.eir = eir; r.ev = ev; r.ed = ed; r.el = el;
    rows.push_back(r);
  endtask

  task automatic feed(input bit u, input int d, input bit l, input bit ev,
                      input logic [WW-1:0] ed, input bit el);
    add(u, 1'b1, d, l, 1'b1, 1'b1, ev, ed, el);
  endtask

  task automatic idle(input bit u);
    add(u, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_row(input row_t r, input int idx);
    a_in_valid  = r.v && !r.u;
    b_in_valid  = r.v && r.u;
    a_in_data   = r.d;
    b_in_data   = r.d;
    a_in_last   = r.l;
    b_in_last   = r.l;
    a_out_ready = r.u ? 1'b1 : r.rdy;
    b_out_ready = r.u ? r.rdy : 1'b1;
    #1;
    check($sformatf("row%0d in_ready", idx), r.u ? b_in_ready : a_in_ready, r.eir);
    @(posedge clk);
    #1;
    check($sformatf("row%0d out_valid", idx), r.u ? b_out_valid : a_out_valid, r.ev);
    if (r.ev) begin
      check($sformatf("row%0d out_data", idx), r.u ? b_out_data : a_out_data, r.ed);
      check($sformatf("row%0d out_last", idx), r.u ? b_out_last : a_out_last, r.el);
    end
  endtask

  task automatic run_rows(input int base);
    for (int i = 0; i < rows.size(); i++) begin
      run_row(rows[i], base + i);
    end
    rows.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    #3;
    check("reset out_valid", a_out_valid, 1'b0);
    check("reset out_data", a_out_data, '0);
    check("reset out_last", a_out_last, 1'b0);
    check("reset in_ready", a_in_ready, 1'b1);
    check("reset b out_valid", b_out_valid, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single window 0..6, valid for exactly one cycle.
    for (int k = 0; k < 7; k++) feed(0, k, 1'b0, k == 6, seq(0), 1'b0);
    idle(0);

    // Backpressure: window held while the next sample waits, then released.
    for (int k = 20; k < 27; k++) feed(0, k, 1'b0, k == 26, seq(20), 1'b0);
    for (int k = 0; k < 5; k++) add(0, 1'b1, 99, 1'b0, 1'b0, 1'b0, 1'b1, seq(20), 1'b0);
    add(0, 1'b1, 30, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int k = 31; k < 37; k++) feed(0, k, 1'b0, k == 36, seq(30), 1'b0);
    idle(0);

    // Partial window at frame end.
    feed(0, -5, 1'b0, 1'b0, '0, 1'b0);
    feed(0, 100, 1'b0, 1'b0, '0, 1'b0);
`ifdef POOL_PAD_PARTIAL_EN
    feed(0, -1, 1'b1, 1'b1, pk(-5, 100, -1, -512, -512, -512, -512), 1'b1);
`else
    feed(0, -1, 1'b1, 1'b0, '0, 1'b0);
`endif
    for (int k = 0; k < 7; k++) feed(0, k, 1'b0, k == 6, seq(0), 1'b0);
    idle(0);

    // Extreme values bit-exact; in_last on a full window.
    feed(0, -512, 1'b0, 1'b0, '0, 1'b0);
    feed(0, 511, 1'b0, 1'b0, '0, 1'b0);
    feed(0, -1, 1'b0, 1'b0, '0, 1'b0);
    feed(0, 0, 1'b0, 1'b0, '0, 1'b0);
    feed(0, 1, 1'b0, 1'b0, '0, 1'b0);
    feed(0, -2, 1'b0, 1'b0, '0, 1'b0);
    feed(0, 2, 1'b1, 1'b1,
         {10'h200, 10'h1FF, 10'h3FF, 10'h000, 10'h001, 10'h3FE, 10'h002}, 1'b1);
    idle(0);

    // STRIDE=2 overlapping windows, then a frame end that restarts the fill.
    for (int k = 1; k < 12; k++) feed(1, k, 1'b0, (k >= 7) && (k % 2 == 1), seq(k - 6), 1'b0);
    feed(1, 12, 1'b0, 1'b0, '0, 1'b0);
    feed(1, 13, 1'b1, 1'b1, seq(7), 1'b1);
    for (int k = 20; k < 27; k++) feed(1, k, 1'b0, k == 26, seq(20), 1'b0);
    idle(1);

    run_rows(0);

    // Reset mid-operation drops a partial window.
    for (int k = 50; k < 54; k++) feed(0, k, 1'b0, 1'b0, '0, 1'b0);
    run_rows(1000);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", a_out_valid, 1'b0);
    check("midreset out_data", a_out_data, '0);
    check("midreset out_last", a_out_last, 1'b0);
    check("midreset in_ready", a_in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("held reset out_valid", a_out_valid, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 10; k < 17; k++) feed(0, k, 1'b0, k == 16, seq(10), 1'b0);
    idle(0);
    run_rows(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
